// File: rtl/awg_pkg.sv
// Shared definitions for the AWG parameter scheduler: command opcodes, payload lengths,
// FSM encodings and parameter reset values.
package awg_pkg;

    localparam logic [7:0] OpType    = 8'h01;
    localparam logic [7:0] OpFreq    = 8'h02;
    localparam logic [7:0] OpAmp     = 8'h03;
    localparam logic [7:0] OpOffs    = 8'h04;
    localparam logic [7:0] OpSwCfg   = 8'h05;
    localparam logic [7:0] OpCommit  = 8'h06;
    localparam logic [7:0] OpSwStart = 8'h07;
    localparam logic [7:0] OpSwStop  = 8'h08;

    localparam logic [9:0] DcOffsetReset = 10'h200;

    typedef enum logic [0:0] {PsIdle, PsPayload} parse_state_e;

    typedef enum logic [1:0] {SwIdle, SwArm, SwRun} sweep_state_e;

    function automatic logic op_known(input logic [7:0] op);
        return (op >= OpType) && (op <= OpSwStop);
    endfunction

    function automatic logic [2:0] payload_len(input logic [7:0] op);
        logic [2:0] len;
        case (op)
            OpType:                 len = 3'd1;
            OpFreq, OpAmp, OpOffs:  len = 3'd2;
            OpSwCfg:                len = 3'd7;
            default:                len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/awg_sweep_engine.sv
// Frequency sweep sequencer: arms on SWSTART, loads the start frequency on the next waveform
// wrap, then steps the frequency every sw_dwell wraps, wrapping back to start past the stop.
module awg_sweep_engine
    import awg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        phase_wrap,
    input  logic [15:0] sw_start,
    input  logic [15:0] sw_stop,
    input  logic [15:0] sw_step,
    input  logic [7:0]  sw_dwell,
    input  logic [15:0] frequency,
    output logic        active,
    output logic        freq_load,
    output logic [15:0] freq_value
);

    sweep_state_e state_q, state_d;
    logic [7:0]   wrap_cnt_q, wrap_cnt_d;
    logic [7:0]   dwell_eff;
    logic [8:0]   cnt_next;
    logic [16:0]  sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SwIdle;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wrap_cnt_d = wrap_cnt_q;
        freq_load  = 1'b0;
        freq_value = sw_start;
        dwell_eff  = (sw_dwell == 8'd0) ? 8'd1 : sw_dwell;
        cnt_next   = {1'b0, wrap_cnt_q} + 9'd1;
        sum        = {1'b0, frequency} + {1'b0, sw_step};

        if (stop) begin
            state_d    = SwIdle;
            wrap_cnt_d = '0;
        end else if (start) begin
            state_d    = SwArm;
            wrap_cnt_d = '0;
        end else if (phase_wrap) begin
            case (state_q)
                SwArm: begin
                    freq_load  = 1'b1;
                    freq_value = sw_start;
                    state_d    = SwRun;
                    wrap_cnt_d = '0;
                end
                SwRun: begin
                    // >= rather than == so a shrinking dwell mid-sweep cannot strand the count
                    if (cnt_next >= {1'b0, dwell_eff}) begin
                        wrap_cnt_d = '0;
                        if (sw_step != 16'd0) begin
                            freq_load = 1'b1;
                            if (sum[16] || (sum > {1'b0, sw_stop})) begin
                                freq_value = sw_start;
                            end else begin
                                freq_value = sum[15:0];
                            end
                        end
                    end else begin
                        wrap_cnt_d = cnt_next[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign active = (state_q != SwIdle);

endmodule

// File: rtl/awg_param_scheduler.sv
// Byte-stream command parser feeding shadow registers; committed values reach the generator
// outputs only on a waveform period boundary, with an optional frequency sweep engine.
module awg_param_scheduler
    import awg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    input  logic        phase_wrap,
    output logic [1:0]  waveform_type,
    output logic [15:0] frequency,
    output logic [9:0]  amplitude,
    output logic [9:0]  dc_offset,
    output logic        cmd_ack,
    output logic        cmd_err,
    output logic        update_pending,
    output logic        sweep_active
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    parse_state_e pstate_q, pstate_d;
    logic [7:0]   op_q, op_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [47:0]  stage_q, stage_d;
    logic [TW-1:0] idle_q, idle_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         wr_en;
    logic         commit;
    logic         sw_start_cmd;
    logic         sw_stop_cmd;
    logic [55:0]  payload;

    logic [1:0]   sh_type_q;
    logic [15:0]  sh_freq_q;
    logic [9:0]   sh_amp_q;
    logic [9:0]   sh_offs_q;
    logic [15:0]  sw_start_q, sw_stop_q, sw_step_q;
    logic [7:0]   sw_dwell_q;

    logic [1:0]   type_q, type_d;
    logic [15:0]  freq_q, freq_d;
    logic [9:0]   amp_q, amp_d;
    logic [9:0]   offs_q, offs_d;
    logic         pending_q, pending_d;

    logic         sw_active;
    logic         sw_load;
    logic [15:0]  sw_value;

    // The final byte is combined with the staged ones so shadows load in the same edge.
    assign payload = {stage_q, cmd_data};

    always_comb begin
        pstate_d     = pstate_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        stage_d      = stage_q;
        idle_d       = idle_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        wr_en        = 1'b0;
        commit       = 1'b0;
        sw_start_cmd = 1'b0;
        sw_stop_cmd  = 1'b0;

        case (pstate_q)
            PsIdle: begin
                if (cmd_valid) begin
                    if (!op_known(cmd_data)) begin
                        err_d = 1'b1;
                    end else if (payload_len(cmd_data) == 3'd0) begin
                        ack_d = 1'b1;
                        case (cmd_data)
                            OpCommit:  commit       = 1'b1;
                            OpSwStart: sw_start_cmd = 1'b1;
                            OpSwStop:  sw_stop_cmd  = 1'b1;
                            default: ;
                        endcase
                    end else begin
                        op_d     = cmd_data;
                        cnt_d    = payload_len(cmd_data);
                        idle_d   = '0;
                        pstate_d = PsPayload;
                    end
                end
            end
            PsPayload: begin
                if (cmd_valid) begin
                    idle_d  = '0;
                    stage_d = {stage_q[39:0], cmd_data};
                    if (cnt_q == 3'd1) begin
                        wr_en    = 1'b1;
                        ack_d    = 1'b1;
                        cnt_d    = '0;
                        pstate_d = PsIdle;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d    = 1'b1;
                    idle_d   = '0;
                    cnt_d    = '0;
                    pstate_d = PsIdle;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            default: pstate_d = PsIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q <= PsIdle;
            op_q     <= '0;
            cnt_q    <= '0;
            stage_q  <= '0;
            idle_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            idle_q   <= idle_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_type_q  <= '0;
            sh_freq_q  <= '0;
            sh_amp_q   <= '0;
            sh_offs_q  <= DcOffsetReset;
            sw_start_q <= '0;
            sw_stop_q  <= '0;
            sw_step_q  <= '0;
            sw_dwell_q <= '0;
        end else if (wr_en) begin
            case (op_q)
                OpType:  sh_type_q <= payload[1:0];
                OpFreq:  sh_freq_q <= payload[15:0];
                OpAmp:   sh_amp_q  <= payload[9:0];
                OpOffs:  sh_offs_q <= payload[9:0];
                OpSwCfg: begin
                    sw_start_q <= payload[55:40];
                    sw_stop_q  <= payload[39:24];
                    sw_step_q  <= payload[23:8];
                    sw_dwell_q <= payload[7:0];
                end
                default: ;
            endcase
        end
    end

    awg_sweep_engine u_sweep (
        .clk        (clk),
        .rst        (rst),
        .start      (sw_start_cmd),
        .stop       (sw_stop_cmd),
        .phase_wrap (phase_wrap),
        .sw_start   (sw_start_q),
        .sw_stop    (sw_stop_q),
        .sw_step    (sw_step_q),
        .sw_dwell   (sw_dwell_q),
        .frequency  (freq_q),
        .active     (sw_active),
        .freq_load  (sw_load),
        .freq_value (sw_value)
    );

    // A COMMIT coinciding with a wrap only arms; the copy waits for a wrap seen while pending.
    always_comb begin
        pending_d = pending_q;
        type_d    = type_q;
        freq_d    = freq_q;
        amp_d     = amp_q;
        offs_d    = offs_q;

        if (phase_wrap && pending_q) begin
            pending_d = 1'b0;
            type_d    = sh_type_q;
            amp_d     = sh_amp_q;
            offs_d    = sh_offs_q;
            if (!sw_active) begin
                freq_d = sh_freq_q;
            end
        end else if (commit) begin
            pending_d = 1'b1;
        end

        if (sw_load) begin
            freq_d = sw_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            type_q    <= '0;
            freq_q    <= '0;
            amp_q     <= '0;
            offs_q    <= DcOffsetReset;
        end else begin
            pending_q <= pending_d;
            type_q    <= type_d;
            freq_q    <= freq_d;
            amp_q     <= amp_d;
            offs_q    <= offs_d;
        end
    end

    assign waveform_type  = type_q;
    assign frequency      = freq_q;
    assign amplitude      = amp_q;
    assign dc_offset      = offs_q;
    assign cmd_ack        = ack_q;
    assign cmd_err        = err_q;
    assign update_pending = pending_q;
    assign sweep_active   = sw_active;

endmodule

// File: tb/tb_awg_param_scheduler.sv
// Scoreboard bench for awg_param_scheduler: expected ack/err events and frequency changes are
// queued as stimulus is driven and matched by a monitor as the DUT produces them.
module tb_awg_param_scheduler;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        phase_wrap;
    logic [1:0]  waveform_type;
    logic [15:0] frequency;
    logic [9:0]  amplitude;
    logic [9:0]  dc_offset;
    logic        cmd_ack;
    logic        cmd_err;
    logic        update_pending;
    logic        sweep_active;

    always #5 clk = ~clk;

    awg_param_scheduler #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .phase_wrap     (phase_wrap),
        .waveform_type  (waveform_type),
        .frequency      (frequency),
        .amplitude      (amplitude),
        .dc_offset      (dc_offset),
        .cmd_ack        (cmd_ack),
        .cmd_err        (cmd_err),
        .update_pending (update_pending),
        .sweep_active   (sweep_active)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [1:0]  ev_q[$];   // 2'b10 = ack, 2'b01 = err
    logic [15:0] fq[$];
    logic [15:0] prev_freq;
    logic [15:0] sweep_exp [9];
    logic [15:0] last_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_freq = frequency;
        end else begin
            if (cmd_ack || cmd_err) begin
                if (ev_q.size() == 0) check("ev_extra", {30'd0, cmd_ack, cmd_err}, 32'd0);
                else check("ev", {30'd0, cmd_ack, cmd_err}, {30'd0, ev_q.pop_front()});
            end
            if (frequency !== prev_freq) begin
                if (fq.size() == 0) check("freq_extra", {16'd0, frequency}, {16'd0, prev_freq});
                else check("freq_step", {16'd0, frequency}, {16'd0, fq.pop_front()});
                prev_freq = frequency;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Bytes packed MSB-first: byte i of n is bytes[(n-1-i)*8 +: 8]; one ack expected.
    task automatic send_frame(input int n, input logic [63:0] bytes);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) ev_q.push_back(2'b10);
            send(bytes[(n - 1 - i) * 8 +: 8]);
        end
    endtask

    task automatic wrap();
        phase_wrap = 1'b1;
        tick();
        phase_wrap = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sweep_exp = '{16'd100, 16'd100, 16'd110, 16'd110, 16'd120, 16'd120,
                      16'd130, 16'd130, 16'd100};
        rst = 1'b1;
        cmd_data = 8'h00;
        cmd_valid = 1'b0;
        phase_wrap = 1'b0;
        idle(3);
        rst = 1'b0;

        check("rst_type", {30'd0, waveform_type}, 32'd0);
        check("rst_freq", {16'd0, frequency}, 32'd0);
        check("rst_amp", {22'd0, amplitude}, 32'd0);
        check("rst_offs", {22'd0, dc_offset}, 32'h200);
        check("rst_pend", {31'd0, update_pending}, 32'd0);
        check("rst_sweep", {31'd0, sweep_active}, 32'd0);
        check("rst_ack", {31'd0, cmd_ack}, 32'd0);
        check("rst_err", {31'd0, cmd_err}, 32'd0);

        // Frequency frame then COMMIT away from a wrap
        send_frame(3, 64'h02_1234);
        check("freq_ack", {31'd0, cmd_ack}, 32'd1);
        send_frame(1, 64'h06);
        check("pend_set", {31'd0, update_pending}, 32'd1);
        idle(2);
        check("freq_hold", {16'd0, frequency}, 32'd0);
        fq.push_back(16'h1234);
        wrap();
        check("freq_commit", {16'd0, frequency}, 32'h1234);
        check("pend_clr", {31'd0, update_pending}, 32'd0);

        // COMMIT landing on a wrap defers the copy to the following wrap
        send_frame(3, 64'h02_ABCD);
        phase_wrap = 1'b1;
        send_frame(1, 64'h06);
        phase_wrap = 1'b0;
        check("coinc_hold", {16'd0, frequency}, 32'h1234);
        check("coinc_pend", {31'd0, update_pending}, 32'd1);
        fq.push_back(16'hABCD);
        wrap();
        check("coinc_commit", {16'd0, frequency}, 32'hABCD);

        // Timeout on a partial amplitude frame
        send(8'h03);
        send(8'h01);
        ev_q.push_back(2'b01);
        idle(TO - 1);
        check("to_early", {31'd0, cmd_err}, 32'd0);
        tick();
        check("to_err", {31'd0, cmd_err}, 32'd1);
        tick();
        send_frame(1, 64'h06);
        wrap();
        check("amp_after_abort", {22'd0, amplitude}, 32'd0);
        send_frame(3, 64'h03_03FF);
        send_frame(1, 64'h06);
        wrap();
        check("amp_full", {22'd0, amplitude}, 32'h3FF);

        // Unknown opcode
        ev_q.push_back(2'b01);
        send(8'h7F);
        check("unk_err", {31'd0, cmd_err}, 32'd1);
        check("unk_noack", {31'd0, cmd_ack}, 32'd0);
        send_frame(2, 64'h01_03);
        send_frame(1, 64'h06);
        wrap();
        check("type_after_unk", {30'd0, waveform_type}, 32'd3);

        // Sweep 100..130 step 10 dwell 2
        send_frame(8, 64'h05_0064_0082_000A_02);
        send_frame(1, 64'h07);
        check("sw_active", {31'd0, sweep_active}, 32'd1);
        check("sw_arm_hold", {16'd0, frequency}, 32'hABCD);
        last_exp = frequency;
        for (int i = 0; i < 9; i++) begin
            if (sweep_exp[i] != last_exp) fq.push_back(sweep_exp[i]);
            last_exp = sweep_exp[i];
            wrap();
            check("sweep_seq", {16'd0, frequency}, {16'd0, sweep_exp[i]});
        end

        // COMMIT during sweep leaves frequency alone
        send_frame(2, 64'h01_01);
        send_frame(3, 64'h03_0123);
        send_frame(3, 64'h04_0055);
        send_frame(3, 64'h02_0F0F);
        send_frame(1, 64'h06);
        wrap();
        check("swc_type", {30'd0, waveform_type}, 32'd1);
        check("swc_amp", {22'd0, amplitude}, 32'h123);
        check("swc_offs", {22'd0, dc_offset}, 32'h055);
        check("swc_freq", {16'd0, frequency}, 32'd100);
        fq.push_back(16'd110);
        wrap();
        check("swc_step", {16'd0, frequency}, 32'd110);
        send_frame(1, 64'h08);
        check("stop_inactive", {31'd0, sweep_active}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            wrap();
            check("stop_frozen", {16'd0, frequency}, 32'd110);
        end

        // Reset in the middle of a SWCFG frame
        send(8'h05);
        send(8'h00);
        send(8'h64);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("mrst_type", {30'd0, waveform_type}, 32'd0);
        check("mrst_freq", {16'd0, frequency}, 32'd0);
        check("mrst_amp", {22'd0, amplitude}, 32'd0);
        check("mrst_offs", {22'd0, dc_offset}, 32'h200);
        check("mrst_sweep", {31'd0, sweep_active}, 32'd0);
        check("mrst_ack", {31'd0, cmd_ack}, 32'd0);
        check("mrst_err", {31'd0, cmd_err}, 32'd0);
        send_frame(2, 64'h01_02);
        send_frame(1, 64'h06);
        wrap();
        check("post_type", {30'd0, waveform_type}, 32'd2);
        check("post_freq", {16'd0, frequency}, 32'd0);
        check("post_amp", {22'd0, amplitude}, 32'd0);
        check("post_offs", {22'd0, dc_offset}, 32'h200);

        idle(3);
        check("evq_empty", ev_q.size(), 32'd0);
        check("fq_empty", fq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/awg_param_scheduler.md
AWG_PARAM_SCHEDULER -- requirements
Module: awg_param_scheduler

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 100000, clk cycles allowed between frame bytes before the partial frame is aborted.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: cmd_data  input  8  received command byte.
REQ-005 SHALL have port: cmd_valid  input  1  one-cycle strobe; cmd_data valid.
REQ-006 SHALL have port: phase_wrap  input  1  one-cycle pulse from the waveform generator at the end of each waveform period.
REQ-007 SHALL have ports: waveform_type  output  2; frequency  output  16; amplitude  output  10; dc_offset  output  10; these are the active generator parameters.
REQ-008 SHALL have ports: cmd_ack  output  1 (frame-accepted pulse); cmd_err  output  1 (frame-error pulse); update_pending  output  1; sweep_active  output  1.

Function
REQ-009 SHALL parse frames as an opcode byte followed by the payload, multi-byte fields MSB first; opcodes and payload lengths: 0x01 TYPE 1 (bits[1:0]), 0x02 FREQ 2, 0x03 AMP 2 (bits[9:0]), 0x04 OFFS 2 (bits[9:0]), 0x05 SWCFG 7 (start 2, stop 2, step 2, dwell 1), 0x06 COMMIT 0, 0x07 SWSTART 0, 0x08 SWSTOP 0.
REQ-010 SHALL use parser FSM states IDLE -> PAYLOAD -> IDLE; a known opcode with payload goes to PAYLOAD with byte counter = length; a zero-length opcode executes in the same cycle and stays in IDLE.
REQ-011 SHALL, on an unknown opcode, pulse cmd_err one cycle after the byte, discard the byte and stay in IDLE.
REQ-012 SHALL assemble the payload in a staging buffer and write shadow registers only when the final payload byte is received; cmd_ack SHALL pulse one cycle after the final byte (or after a zero-length opcode).
REQ-013 SHALL, in PAYLOAD, count idle cycles since the last cmd_valid; on reaching TIMEOUT_CYCLES it SHALL pulse cmd_err, return to IDLE and leave all shadow registers unchanged.
REQ-014 SHALL hold shadow registers (type, freq, amp, offset, sw_start, sw_stop, sw_step, sw_dwell); writing a shadow register SHALL NOT change any output.
REQ-015 SHALL, on COMMIT, set update_pending; on the first phase_wrap where update_pending is already 1, it SHALL copy the shadow values to the outputs in that cycle (visible the next cycle) and clear update_pending.
REQ-016 SHALL, when COMMIT and phase_wrap coincide with update_pending=0, defer the copy to the next phase_wrap; a second COMMIT while pending SHALL have no additional effect.
REQ-017 SHALL use sweep FSM states SW_IDLE -> SW_ARM -> SW_RUN -> SW_IDLE; SWSTART moves SW_IDLE->SW_ARM; SW_ARM loads frequency=sw_start on the next phase_wrap and enters SW_RUN; sweep_active=1 in SW_ARM and SW_RUN.
REQ-018 SHALL, in SW_RUN, count phase_wrap pulses; when the count equals sw_dwell (0 treated as 1) it SHALL reset the count and set frequency = frequency + sw_step, computed 17 bits wide.
REQ-019 SHALL reload frequency = sw_start when the 17-bit sum exceeds sw_stop or 0xFFFF; sw_step=0 SHALL hold frequency constant.
REQ-020 SHALL, while sweep_active, apply COMMIT to type, amplitude and offset only, leaving frequency sweep-controlled.
REQ-021 SHALL, on SWSTOP, return to SW_IDLE immediately and keep the current frequency; SWSTART while sweep_active SHALL restart from SW_ARM.
REQ-022 SHALL treat a cmd_valid arriving in the same cycle as phase_wrap as independent; both events take effect.

Reset
REQ-023 SHALL, with rst=1 at a clk edge, set waveform_type=0, frequency=0, amplitude=0, dc_offset=0x200, every shadow register equal to its output (sw_* = 0), update_pending=0, sweep_active=0, cmd_ack=0, cmd_err=0, both FSMs idle and all counters 0.
REQ-024 SHALL discard a partially received frame when reset is applied mid-frame, with no ack or err pulse.

Structure
REQ-025 SHALL place opcode constants, payload-length table, FSM state encodings and the reset value of dc_offset in a shared package awg_pkg.
REQ-026 SHALL implement the sweep logic as a single sub-module awg_sweep_engine; the parser and commit logic SHALL remain in the top module.

Verification
REQ-027 SHALL cover: 0x02,0x12,0x34 then 0x06 -> frequency stays 0 until the second phase_wrap after COMMIT if COMMIT lands on a wrap, otherwise until the first phase_wrap; then frequency=0x1234; one cmd_ack per frame.
REQ-028 SHALL cover: 0x03,0x01 followed by TIMEOUT_CYCLES idle cycles -> cmd_err pulse, amplitude shadow unchanged; the next 0x03,0x03,0xFF,0x06 and a phase_wrap -> amplitude=0x3FF.
REQ-029 SHALL cover: opcode 0x7F -> cmd_err pulse, no ack; the parser accepts the next frame normally.
REQ-030 SHALL cover: SWCFG start=100, stop=130, step=10, dwell=2, then SWSTART -> after the first wrap frequency=100, then frequency goes 110, 120, 130, 100 with one step every 2 wraps.
REQ-031 SHALL cover: a sweep in progress with SWSTOP -> sweep_active=0 next cycle and frequency frozen; COMMIT during the sweep changes only type, amplitude and offset.
REQ-032 SHALL cover: rst asserted after the 2nd byte of SWCFG -> all outputs at their reset values; a following 0x01,0x02,0x06 plus a wrap -> waveform_type=2.
